// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core data port and dmem; loads bypass, stall on, or forward from queued stores.
// Define STORE_FWD_EN to forward full-word matches to loads; otherwise any address match stalls the load.
module dmem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  input  logic [3:0]  core_mask_i,
  output logic [31:0] core_rd_o,
  output logic        core_wait_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  output logic [3:0]  mem_mask_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_wait_i,
  output logic        sb_empty_o
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD} state_e;

  state_e        state_q;
  logic [29:0]   ent_addr_q [DEPTH];
  logic [31:0]   ent_data_q [DEPTH];
  logic [3:0]    ent_mask_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q, drain_idx;
  logic [PW:0]   cnt_q, cnt_d;
  logic          mem_req_q, mem_we_q;
  logic [31:0]   mem_addr_q, mem_wd_q;
  logic [3:0]    mem_mask_q;

  logic          is_store, is_load, full, enq, deq, hit, fwd_ok, load_go;
  logic          advance, go_load, go_drain;
  logic [31:0]   fwd_data;
  logic          unused_addr_lsb;
`ifdef STORE_FWD_EN
  logic [3:0]    ymask;
`endif

  assign unused_addr_lsb = ^core_addr_i[1:0];

  assign is_store = core_req_i && core_we_i;
  assign is_load  = core_req_i && !core_we_i;
  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign enq      = is_store && !full;
  assign deq      = (state_q == DRAIN) && !mem_wait_i;
  assign cnt_d    = cnt_q + (PW+1)'(enq) - (PW+1)'(deq);

  // Scan oldest to youngest so the last match seen is the youngest entry.
  always_comb begin
    hit      = 1'b0;
    fwd_ok   = 1'b0;
    fwd_data = 32'h0;
`ifdef STORE_FWD_EN
    ymask    = 4'h0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (((PW+1)'(k) < cnt_q) && (ent_addr_q[rptr_q + PW'(k)] == core_addr_i[31:2])) begin
        hit = 1'b1;
`ifdef STORE_FWD_EN
        ymask    = ent_mask_q[rptr_q + PW'(k)];
        fwd_data = ent_data_q[rptr_q + PW'(k)];
`endif
      end
    end
`ifdef STORE_FWD_EN
    fwd_ok = is_load && hit && (ymask == 4'hF);
`endif
  end

  assign load_go   = is_load && !hit;
  assign advance   = (state_q == IDLE) || !mem_wait_i;
  // The load completing in LOAD is not a new pending load.
  assign go_load   = advance && load_go && (state_q != LOAD);
  assign go_drain  = advance && !go_load &&
                     ((state_q == DRAIN) ? (cnt_q > (PW+1)'(1)) : (cnt_q != '0));
  assign drain_idx = (state_q == DRAIN) ? rptr_q + PW'(1) : rptr_q;

  always_comb begin
    core_wait_o = 1'b1;
    core_rd_o   = 32'h0;
    if (reset_i) begin
      if (is_store) begin
        core_wait_o = full;
      end else if (fwd_ok) begin
        core_wait_o = 1'b0;
        core_rd_o   = fwd_data;
      end else if (is_load && (state_q == LOAD) && !mem_wait_i) begin
        core_wait_o = 1'b0;
        core_rd_o   = mem_rd_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      ent_addr_q[wptr_q] <= core_addr_i[31:2];
      ent_data_q[wptr_q] <= core_wd_i;
      ent_mask_q[wptr_q] <= core_mask_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 32'h0;
      mem_wd_q   <= 32'h0;
      mem_mask_q <= 4'h0;
    end else begin
      cnt_q <= cnt_d;
      if (enq) wptr_q <= wptr_q + PW'(1);
      if (deq) rptr_q <= rptr_q + PW'(1);
      if (go_load) begin
        state_q    <= LOAD;
        mem_req_q  <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= {core_addr_i[31:2], 2'b00};
        mem_wd_q   <= 32'h0;
        mem_mask_q <= 4'hF;
      end else if (go_drain) begin
        state_q    <= DRAIN;
        mem_req_q  <= 1'b1;
        mem_we_q   <= 1'b1;
        mem_addr_q <= {ent_addr_q[drain_idx], 2'b00};
        mem_wd_q   <= ent_data_q[drain_idx];
        mem_mask_q <= ent_mask_q[drain_idx];
      end else if (advance) begin
        state_q    <= IDLE;
        mem_req_q  <= 1'b0;
        mem_we_q   <= 1'b0;
        mem_addr_q <= 32'h0;
        mem_wd_q   <= 32'h0;
        mem_mask_q <= 4'h0;
      end
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_wd_o   = mem_wd_q;
  assign mem_mask_o = mem_mask_q;
  assign sb_empty_o = (cnt_q == '0) && (state_q != DRAIN);

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed scenarios plus random traffic against an architectural memory model.
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, core_wait, mem_req, mem_we, mem_wait, sb_empty;
  logic [31:0] core_addr, core_wd, core_rd, mem_addr, mem_wd, mem_rd;
  logic [3:0]  core_mask, mem_mask;

  dmem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(reset),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wd_i(core_wd), .core_mask_i(core_mask),
    .core_rd_o(core_rd), .core_wait_o(core_wait),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wd_o(mem_wd), .mem_mask_o(mem_mask),
    .mem_rd_i(mem_rd), .mem_wait_i(mem_wait), .sb_empty_o(sb_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [29:0] wa; logic [31:0] d; logic [3:0] m;} st_t;

  st_t         sq[$];       // accepted stores not yet written to dmem, oldest first
  logic [32:0] tlog[$];     // completed dmem transactions {we, addr}
  logic [31:0] dmem [512];  // the dmem device
  logic [31:0] arch [512];  // architectural memory: every accepted store applied in order
  int          checks, failures, cyc, writes, reads, wr_first, st_cyc, mw_mode;
  bit          ld_done, st_done;
  logic [31:0] last_rd_addr;

  assign mem_rd = dmem[mem_addr[10:2]];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven at the falling edge, outputs sampled 1 time unit later.
  task automatic step();
    int pre;
    if (mw_mode == 2) mem_wait = ($urandom_range(0, 1) == 1);
    else              mem_wait = (mw_mode == 1);
    #1;
    pre = sq.size();
    ld_done = 0;
    st_done = 0;
    chk("sb_empty", 32'(sb_empty), 32'(pre == 0));
    if (mem_req && !mem_wait) begin
      tlog.push_back({mem_we, mem_addr});
      if (mem_we) begin
        writes++;
        if (wr_first < 0) wr_first = cyc;
        chk("wr_pending", 32'(pre != 0), 32'd1);
        if (pre != 0) begin
          chk("wr_addr", mem_addr, {sq[0].wa, 2'b00});
          chk("wr_data", mem_wd, sq[0].d);
          chk("wr_mask", 32'(mem_mask), 32'(sq[0].m));
          void'(sq.pop_front());
        end
        dmem[mem_addr[10:2]] = merge(dmem[mem_addr[10:2]], mem_wd, mem_mask);
      end else begin
        reads++;
        last_rd_addr = mem_addr;
        chk("rd_mask", 32'(mem_mask), 32'hF);
      end
    end
    if (core_req && core_we) begin
      chk("st_wait", 32'(core_wait), 32'(pre == DEPTH));
      if (!core_wait) begin
        sq.push_back('{wa: core_addr[31:2], d: core_wd, m: core_mask});
        arch[core_addr[10:2]] = merge(arch[core_addr[10:2]], core_wd, core_mask);
        st_done = 1;
        st_cyc  = cyc;
      end
    end else if (core_req && !core_we && !core_wait) begin
      chk("ld_data", core_rd, arch[core_addr[10:2]]);
      ld_done = 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          input int hold, output int w);
    core_req = 1; core_we = 1; core_addr = a; core_wd = d; core_mask = m;
    w = 0;
    for (int i = 0; i < hold; i++) begin step(); chk("st_hold", 32'(st_done), 0); w++; end
    if (hold > 0) mw_mode = 0;
    step();
    while (!st_done && w < 200) begin w++; step(); end
    chk("st_done", 32'(st_done), 1);
    core_req = 0; core_we = 0;
  endtask

  task automatic do_load(input logic [31:0] a, input int hold, output int w);
    core_req = 1; core_we = 0; core_addr = a; core_wd = $urandom; core_mask = 4'($urandom);
    w = 0;
    for (int i = 0; i < hold; i++) begin step(); chk("ld_hold", 32'(ld_done), 0); w++; end
    if (hold > 0) mw_mode = 0;
    step();
    while (!ld_done && w < 200) begin w++; step(); end
    chk("ld_done", 32'(ld_done), 1);
    core_req = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    mw_mode = 0;
    core_req = 0;
    while (sq.size() != 0 && n < 300) begin step(); n++; end
    chk("drain_done", 32'(sq.size()), 0);
    step();
  endtask

  initial begin
    int w, r0, w0;
    logic [31:0] a;
    logic [32:0] lg [3];
    checks = 0; failures = 0; cyc = 0; writes = 0; reads = 0; wr_first = -1; st_cyc = -1;
    mw_mode = 0; mem_wait = 0; last_rd_addr = '0;
    reset = 0; core_req = 0; core_we = 0; core_addr = 0; core_wd = 0; core_mask = 0;
    for (int i = 0; i < 512; i++) begin dmem[i] = $urandom; arch[i] = dmem[i]; end
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wd", mem_wd, 0);
    chk("rst_mem_mask", 32'(mem_mask), 0);
    chk("rst_core_wait", 32'(core_wait), 1);
    chk("rst_core_rd", core_rd, 0);
    chk("rst_sb_empty", 32'(sb_empty), 1);
    @(negedge clk); @(negedge clk);
    reset = 1;

    // Back-to-back stores with a fast dmem
    do_store(32'h100, 32'h11111111, 4'hF, 0, w); chk("b2b_w0", 32'(w), 0);
    do_store(32'h104, 32'h22222222, 4'hF, 0, w); chk("b2b_w1", 32'(w), 0);
    do_store(32'h108, 32'h33333333, 4'hF, 0, w); chk("b2b_w2", 32'(w), 0);
    drain();
    chk("b2b_d0", dmem[64], 32'h11111111);
    chk("b2b_d1", dmem[65], 32'h22222222);
    chk("b2b_d2", dmem[66], 32'h33333333);

    // Full buffer: dmem stalled, fifth store waits for the first drain
    mw_mode = 1;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h110 + 32'(4 * i), $urandom, 4'hF, 0, w);
      chk("full_fill_w", 32'(w), 0);
    end
    wr_first = -1;
    do_store(32'h120, 32'h55555555, 4'hF, 3, w);
    chk("full_stall", 32'(w), 4);
    chk("full_acc_cyc", 32'(st_cyc), 32'(wr_first + 1));
    drain();

    // Load to a word with a full-mask store still queued
    mw_mode = 1;
    do_store(32'h200, 32'hDEADBEEF, 4'hF, 0, w);
    r0 = reads;
`ifdef STORE_FWD_EN
    do_load(32'h200, 0, w);
    chk("fwd_w", 32'(w), 0);
    chk("fwd_noread", 32'(reads), 32'(r0));
`else
    do_load(32'h200, 3, w);
    chk("nofwd_stalled", 32'(w >= 4), 1);
    chk("nofwd_read", 32'(reads), 32'(r0 + 1));
    chk("nofwd_addr", last_rd_addr, 32'h200);
`endif
    drain();

    // Partial-mask store blocks the load until it drains
    mw_mode = 1;
    do_store(32'h300, $urandom, 4'b0001, 0, w);
    r0 = reads;
    do_load(32'h302, 3, w);
    chk("part_stalled", 32'(w >= 4), 1);
    chk("part_read", 32'(reads), 32'(r0 + 1));
    chk("part_addr", last_rd_addr, 32'h300);
    drain();

    // Load to an unrelated word slips ahead of the queued second store
    mw_mode = 1;
    tlog.delete();
    do_store(32'h400, $urandom, 4'hF, 0, w);
    do_store(32'h404, $urandom, 4'hF, 0, w);
    chk("byp_inflight", 32'(mem_req && mem_we), 1);
    do_load(32'h500, 2, w);
    drain();
    chk("byp_n", 32'(tlog.size()), 3);
    for (int i = 0; i < 3; i++) lg[i] = (i < tlog.size()) ? tlog[i] : 33'h0;
    chk("byp_t0", lg[0][31:0] | {31'h0, lg[0][32]}, 32'h401);
    chk("byp_t1", lg[1][31:0] | {31'h0, lg[1][32]}, 32'h500);
    chk("byp_t2", lg[2][31:0] | {31'h0, lg[2][32]}, 32'h405);

    // Reset in the middle of a drain discards everything queued
    mw_mode = 1;
    do_store(32'h600, $urandom, 4'hF, 0, w);
    do_store(32'h604, $urandom, 4'hF, 0, w);
    do_store(32'h608, $urandom, 4'hF, 0, w);
    chk("rst_pre_req", 32'(mem_req), 1);
    core_req = 1; core_we = 1; core_addr = 32'h60C; core_wd = $urandom; core_mask = 4'hF;
    #2 reset = 0;
    #1;
    chk("rstm_mem_req", 32'(mem_req), 0);
    chk("rstm_sb_empty", 32'(sb_empty), 1);
    chk("rstm_core_wait", 32'(core_wait), 1);
    @(negedge clk); #1;
    chk("rstm_hold_req", 32'(mem_req), 0);
    chk("rstm_hold_wait", 32'(core_wait), 1);
    sq.delete();
    for (int i = 0; i < 512; i++) arch[i] = dmem[i];
    @(negedge clk);
    reset = 1; core_req = 0; core_we = 0;
    w0 = writes; mw_mode = 0;
    repeat (8) step();
    chk("rstm_no_wr", 32'(writes), 32'(w0));

    // Random traffic on a small set of words with a random dmem stall
    mw_mode = 2;
    for (int i = 0; i < 250; i++) begin
      int rr;
      rr = $urandom_range(0, 9);
      a  = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      if (rr < 5)
        do_store(a, $urandom, ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(1, 15)), 0, w);
      else if (rr < 9)
        do_load(a, 0, w);
      else begin
        core_req = 0;
        step();
      end
    end
    drain();
    for (int i = 64; i < 72; i++) chk("rand_final", dmem[i], arch[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
